pulse_height_detector: RTL and testbench



---
 rtl/pulse_height_detector_pkg.sv | 28 ++
 rtl/pulse_height_detector_fifo.sv | 50 +++++
 rtl/pulse_height_detector.sv | 168 ++++++++++++++++
 tb/tb_pulse_height_detector.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_height_detector_pkg.sv
// Shared types and default settings for the pulse height detector.
// The sample width follows the upstream trapezoidal shaping filter.
package pulse_height_detector_pkg;

  localparam int SIZE_FILTER_DATA = 16;

  localparam int PHD_DATA_W     = SIZE_FILTER_DATA;
  localparam int PHD_TS_W       = 32;
  localparam int PHD_WID_W      = 12;
  localparam int PHD_MAX_WIDTH  = 200;
  localparam int PHD_HOLDOFF    = 8;
  localparam int PHD_FIFO_DEPTH = 4;
  localparam int PHD_BL_SHIFT   = 6;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    HOLD
  } phd_state_t;

  typedef struct packed {
    logic [PHD_DATA_W-1:0] amp;
    logic [PHD_TS_W-1:0]   ts;
    logic [PHD_WID_W-1:0]  width;
    logic                  pileup;
  } phd_event_t;

endpackage

// File: rtl/pulse_height_detector_fifo.sv
// Small synchronous event FIFO; head is presented with valid/ready.
// Head data reads as zero whenever the FIFO is empty.
module phd_event_fifo
  import pulse_height_detector_pkg::*;
#(
  parameter int DEPTH = PHD_FIFO_DEPTH
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_valid,
  input  phd_event_t wr_data,
  output logic       full,
  output logic       rd_valid,
  input  logic       rd_ready,
  output phd_event_t rd_data
);

  localparam int AW = $clog2(DEPTH);

  phd_event_t mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        empty;
  logic        do_wr;
  logic        do_rd;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_rd = rd_ready && !empty;
  // A pop in the same cycle frees the slot, so a write into a full FIFO still lands.
  assign do_wr = wr_valid && (!full || do_rd);

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  assign rd_valid = !empty;
  assign rd_data  = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/pulse_height_detector.sv
// Turns shaped pulses into event records (peak, timestamp, width, pile-up).
// PHD_BASELINE_EN adds a running baseline subtracted from each sample.
//   state  | meaning
//   IDLE   | waiting for a sample above threshold; baseline tracks here
//   ACTIVE | pulse over threshold; tracking peak and width
//   HOLD   | dead time after a pulse; input ignored
module pulse_height_detector
  import pulse_height_detector_pkg::*;
#(
  parameter int DATA_W     = PHD_DATA_W,
  parameter int TS_W       = PHD_TS_W,
  parameter int WID_W      = PHD_WID_W,
  parameter int MAX_WIDTH  = PHD_MAX_WIDTH,
  parameter int HOLDOFF    = PHD_HOLDOFF,
  parameter int FIFO_DEPTH = PHD_FIFO_DEPTH
`ifdef PHD_BASELINE_EN
  ,
  parameter int BL_SHIFT   = PHD_BL_SHIFT
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic [DATA_W-1:0] threshold,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [DATA_W-1:0] evt_amp,
  output logic [TS_W-1:0]   evt_ts,
  output logic [WID_W-1:0]  evt_width,
  output logic              evt_pileup,
  output logic [15:0]       drop_cnt,
  output logic              busy
);

  localparam int HC_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

  phd_state_t               state, state_next;
  logic        [TS_W-1:0]   ts_cnt;
  logic signed [DATA_W-1:0] c;
  logic signed [DATA_W-1:0] thr_r;
  logic signed [DATA_W-1:0] amp_r;
  logic        [TS_W-1:0]   ts_r;
  logic        [WID_W-1:0]  width_r;
  logic        [HC_W-1:0]   hold_cnt;
  logic                     start, extend, finish;
  logic                     fifo_full, pop;
  phd_event_t               evt_wr, evt_rd;

`ifdef PHD_BASELINE_EN
  localparam int BL_W = DATA_W + BL_SHIFT;

  logic signed [BL_W-1:0] bl;
  logic signed [BL_W-1:0] bl_mean;
  logic signed [DATA_W:0] diff;

  assign bl_mean = bl >>> BL_SHIFT;
  assign diff    = (DATA_W+1)'($signed(in_data)) - (DATA_W+1)'(bl_mean);

  always_comb begin
    c = diff[DATA_W-1:0];
    if (diff[DATA_W] != diff[DATA_W-1])
      c = diff[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
  end

  always_ff @(posedge clk) begin
    if (reset) bl <= '0;
    else if (state == IDLE && in_valid) bl <= bl + BL_W'($signed(in_data)) - bl_mean;
  end
`else
  assign c = $signed(in_data);
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    start      = 1'b0;
    extend     = 1'b0;
    finish     = 1'b0;
    unique case (state)
      IDLE: begin
        if (in_valid && c > $signed(threshold)) begin
          start      = 1'b1;
          state_next = ACTIVE;
        end
      end
      ACTIVE: begin
        if (in_valid) begin
          if (c > thr_r) begin
            extend = 1'b1;
          end else begin
            finish     = 1'b1;
            state_next = (HOLDOFF > 0) ? HOLD : IDLE;
          end
        end
      end
      HOLD: begin
        if (hold_cnt == '0) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ts_cnt   <= '0;
      thr_r    <= '0;
      amp_r    <= '0;
      ts_r     <= '0;
      width_r  <= '0;
      hold_cnt <= '0;
    end else begin
      ts_cnt <= ts_cnt + 1'b1;
      if (start) begin
        thr_r   <= $signed(threshold);
        amp_r   <= c;
        ts_r    <= ts_cnt;
        width_r <= WID_W'(1);
      end
      if (extend) begin
        if (c > amp_r)       amp_r   <= c;
        if (width_r != '1)   width_r <= width_r + 1'b1;
      end
      // Dead-time down-counter: HOLD exits on the cycle it reads zero.
      if (finish)              hold_cnt <= HC_W'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);
      else if (state == HOLD)  hold_cnt <= hold_cnt - 1'b1;
    end
  end

  always_comb begin
    evt_wr        = '0;
    evt_wr.amp    = amp_r;
    evt_wr.ts     = ts_r;
    evt_wr.width  = width_r;
    evt_wr.pileup = (int'(width_r) >= MAX_WIDTH);
  end

  phd_event_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .wr_valid (finish),
    .wr_data  (evt_wr),
    .full     (fifo_full),
    .rd_valid (evt_valid),
    .rd_ready (evt_ready),
    .rd_data  (evt_rd)
  );

  assign pop = evt_valid && evt_ready;

  always_ff @(posedge clk) begin
    if (reset)                                            drop_cnt <= '0;
    else if (finish && fifo_full && !pop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 1'b1;
  end

  assign evt_amp    = evt_rd.amp;
  assign evt_ts     = evt_rd.ts;
  assign evt_width  = evt_rd.width;
  assign evt_pileup = evt_rd.pileup;
  assign busy       = (state != IDLE);

endmodule

// File: tb/tb_pulse_height_detector.sv
// Self-checking bench: behavioural event model plus hand-computed expectations.
module tb_pulse_height_detector;

  localparam int MAX_WIDTH  = 200;
  localparam int HOLDOFF    = 8;
  localparam int FIFO_DEPTH = 4;
  localparam int BL_SHIFT   = 6;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic [15:0] threshold = 16'd100;
  logic        evt_valid;
  logic        evt_ready = 1'b1;
  logic [15:0] evt_amp;
  logic [31:0] evt_ts;
  logic [11:0] evt_width;
  logic        evt_pileup;
  logic [15:0] drop_cnt;
  logic        busy;

  always #5 clk = ~clk;

  pulse_height_detector dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .threshold  (threshold),
    .evt_valid  (evt_valid),
    .evt_ready  (evt_ready),
    .evt_amp    (evt_amp),
    .evt_ts     (evt_ts),
    .evt_width  (evt_width),
    .evt_pileup (evt_pileup),
    .drop_cnt   (drop_cnt),
    .busy       (busy)
  );

  typedef struct {
    longint amp;
    longint ts;
    longint width;
    bit     pileup;
  } ev_t;

  ev_t    q[$];
  longint cyc, hold_last, m_drop, cur_amp, cur_ts, cur_n, thr_l;
  bit     in_pulse;
  int     vecs = 0;
  int     miss = 0;
  int     dut_pops = 0;
`ifdef PHD_BASELINE_EN
  longint bl;
`endif

  task automatic check(input string name, input longint act, input longint exp);
    vecs++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic longint corr(input longint d);
    longint r;
    r = d;
`ifdef PHD_BASELINE_EN
    r = d - (bl >>> BL_SHIFT);
    if (r > 32767)  r = 32767;
    if (r < -32768) r = -32768;
`endif
    return r;
  endfunction

  // Event model: per-sample rules, with dead time as an absolute cycle bound.
  always @(posedge clk) begin
    longint d, cv;
    ev_t    e;
    if (reset) begin
      cyc = 0; hold_last = -1; in_pulse = 0; m_drop = 0; q.delete();
`ifdef PHD_BASELINE_EN
      bl = 0;
`endif
    end else begin
      if (q.size() > 0 && evt_ready) void'(q.pop_front());
      d  = longint'($signed(in_data));
      cv = corr(d);
      if (in_valid && in_pulse) begin
        if (cv > thr_l) begin
          cur_n++;
          if (cv > cur_amp) cur_amp = cv;
        end else begin
          e.amp = cur_amp; e.ts = cur_ts;
          e.width = (cur_n > 4095) ? 4095 : cur_n;
          e.pileup = (cur_n >= MAX_WIDTH);
          if (q.size() < FIFO_DEPTH) q.push_back(e);
          else if (m_drop < 65535)   m_drop++;
          in_pulse = 0;
          hold_last = cyc + HOLDOFF;
        end
      end else if (in_valid && cyc > hold_last) begin
        if (cv > longint'($signed(threshold))) begin
          in_pulse = 1; thr_l = longint'($signed(threshold));
          cur_amp = cv; cur_ts = cyc; cur_n = 1;
        end
`ifdef PHD_BASELINE_EN
        bl = bl + d - (bl >>> BL_SHIFT);
`endif
      end
      cyc++;
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      check("busy", longint'(busy), longint'(in_pulse || cyc <= hold_last));
      check("evt_valid", longint'(evt_valid), longint'(q.size() > 0));
      check("drop_cnt", longint'(drop_cnt), m_drop);
      if (q.size() > 0 && evt_valid) begin
        check("evt_amp", longint'($signed(evt_amp)), q[0].amp);
        check("evt_ts", longint'(evt_ts), q[0].ts);
        check("evt_width", longint'(evt_width), q[0].width);
        check("evt_pileup", longint'(evt_pileup), longint'(q[0].pileup));
      end
      if (evt_valid && evt_ready) dut_pops++;
    end
  end

  task automatic smp(input bit v, input int d);
    in_valid = v;
    in_data  = 16'(d);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) smp(1'b0, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0; in_data = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int p0;
    int wl[3];
    do_reset();
    check("rst_valid", longint'(evt_valid), 0);
    check("rst_amp", longint'(evt_amp), 0);
    check("rst_ts", longint'(evt_ts), 0);
    check("rst_width", longint'(evt_width), 0);
    check("rst_pileup", longint'(evt_pileup), 0);
    check("rst_drop", longint'(drop_cnt), 0);
    check("rst_busy", longint'(busy), 0);

`ifdef PHD_BASELINE_EN
    threshold = 16'd100; evt_ready = 1'b1;
    repeat (2000) smp(1'b1, 40);
    repeat (3) smp(1'b1, 340);
    in_valid = 1'b1; in_data = 16'd40;
    @(negedge clk);
    check("bl_valid", longint'(evt_valid), 1);
    check("bl_amp_near_300", longint'($signed(evt_amp) >= 299 && $signed(evt_amp) <= 301), 1);
    idle(12);
`else
    // Basic pulse: 150 crosses at cycle 2.
    threshold = 16'd100; evt_ready = 1'b1; p0 = dut_pops;
    smp(1'b1, 0); smp(1'b1, 50); smp(1'b1, 150); smp(1'b1, 300); smp(1'b1, 250);
    in_valid = 1'b1; in_data = 16'd80;
    check("t1_valid_pre", longint'(evt_valid), 0);
    @(negedge clk);
    check("t1_valid", longint'(evt_valid), 1);
    check("t1_amp", longint'($signed(evt_amp)), 300);
    check("t1_width", longint'(evt_width), 3);
    check("t1_ts", longint'(evt_ts), 2);
    check("t1_pileup", longint'(evt_pileup), 0);
    smp(1'b1, 0); idle(12);
    check("t1_pops", dut_pops - p0, 1);
    smp(1'b1, 100);
    check("thr_equal_no_trigger", longint'(busy), 0);
    idle(2);

    // Hold-off: pulse 3 cycles after the end is ignored, 9 cycles after is taken.
    do_reset(); p0 = dut_pops;
    smp(1'b1, 200); smp(1'b1, 0);
    smp(1'b1, 0); smp(1'b1, 0);
    smp(1'b1, 200); smp(1'b1, 200); smp(1'b1, 0);
    smp(1'b1, 0); smp(1'b1, 0);
    check("hold_busy_last", longint'(busy), 1);
    smp(1'b1, 0);
    check("hold_busy_done", longint'(busy), 0);
    check("hold_one_event", dut_pops - p0, 1);
    smp(1'b1, 200); smp(1'b1, 0); idle(12);
    check("hold_two_events", dut_pops - p0, 2);

    // Six pulses into a stalled 4-deep FIFO; crossings at cycles 0,10,20,...
    do_reset(); evt_ready = 1'b0;
    repeat (6) begin smp(1'b1, 200); smp(1'b1, 0); idle(8); end
    check("full_drop", longint'(drop_cnt), 2);
    evt_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("full_pop_valid", longint'(evt_valid), 1);
      check("full_pop_ts", longint'(evt_ts), 10 * i);
      @(negedge clk);
    end
    check("full_empty", longint'(evt_valid), 0);

    // Reset while ACTIVE discards the partial event and clears drop_cnt.
    smp(1'b1, 200); smp(1'b1, 300);
    check("rst_mid_busy_pre", longint'(busy), 1);
    reset = 1'b1; in_valid = 1'b1; in_data = 16'd0;
    @(negedge clk);
    check("rst_mid_busy", longint'(busy), 0);
    check("rst_mid_valid", longint'(evt_valid), 0);
    check("rst_mid_drop", longint'(drop_cnt), 0);
    reset = 1'b0;
    smp(1'b1, 0); smp(1'b1, 0);
    check("rst_mid_no_event", longint'(evt_valid), 0);

    // Pile-up boundary at MAX_WIDTH.
    do_reset(); evt_ready = 1'b0;
    wl = '{199, 200, 250};
    for (int k = 0; k < 3; k++) begin
      repeat (wl[k]) smp(1'b1, 500);
      smp(1'b1, 0); idle(8);
    end
    evt_ready = 1'b1;
    check("pu_w199", longint'(evt_width), 199);
    check("pu_p199", longint'(evt_pileup), 0);
    @(negedge clk);
    check("pu_w200", longint'(evt_width), 200);
    check("pu_p200", longint'(evt_pileup), 1);
    @(negedge clk);
    check("pu_w250", longint'(evt_width), 250);
    check("pu_p250", longint'(evt_pileup), 1);
    check("pu_a250", longint'($signed(evt_amp)), 500);
    idle(4);

    // Width counter saturation.
    do_reset(); evt_ready = 1'b0;
    repeat (4100) smp(1'b1, 500);
    smp(1'b1, 0);
    check("sat_width", longint'(evt_width), 4095);
    check("sat_pileup", longint'(evt_pileup), 1);
    evt_ready = 1'b1; idle(12);

    // Negative threshold, in_valid gaps, threshold change mid-pulse.
    do_reset(); evt_ready = 1'b0; threshold = 16'hFFCE;
    smp(1'b1, -100); smp(1'b1, -20);
    threshold = 16'd1000;
    smp(1'b0, -200); smp(1'b1, 10); smp(1'b0, 0); smp(1'b1, -60);
    check("neg_amp", longint'($signed(evt_amp)), 10);
    check("neg_width", longint'(evt_width), 2);
    check("neg_ts", longint'(evt_ts), 1);
    evt_ready = 1'b1; idle(12);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
